// File: rtl/fifo_flush_pkg.sv
// Shared types and constants for the flush FIFO drain scheduler.
// Latency: none (declarations only).
// Backpressure: n/a.
package fifo_flush_pkg;

    // Depth of the flush FIFO this scheduler serves.
    localparam int FIFO_DEPTH = 32;

    // Default width of the per-requester drain length and the drained counter.
    localparam int DEF_LEN_W  = 6;

    // Scheduler FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_flush_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot winner is the first set request strictly after i_ptr, with wrap.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the winner is taken and moves the pointer.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
)(
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [PTR_W-1:0] o_idx
);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_hi;
    logic [N-1:0] w_sel;

    // Mask of positions strictly above the pointer; these get first look.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (i > int'(i_ptr));
        end
    end

    // Prefer requests above the pointer, otherwise wrap to the full vector.
    assign w_hi  = i_req & w_mask;
    assign w_sel = (|w_hi) ? w_hi : i_req;

    // Isolate the lowest set bit of the chosen vector.
    assign o_gnt = w_sel & (~w_sel + N'(1));

    // Encode the one-hot winner so the caller can store it as the new pointer.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (o_gnt[i]) begin
                o_idx = PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/fifo_flush_sched.sv
// Flush/drain scheduler: round-robin grants one requester, strobes FIFO reads until len words or empty (len 0).
// Latency: request to grant 1 cycle; done_o pulses the cycle after the last read (or abort).
// Backpressure: reads stall on fifo_empty_i or !rd_ready_i; optional watchdog FIFO_FLUSH_SCHED_WDOG_EN aborts long stalls.
module fifo_flush_sched
    import fifo_flush_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int WDOG_CYCLES = 64
)(
    input  logic                     rclock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*LEN_W-1:0] len_i,
    input  logic                     fifo_empty_i,
    input  logic                     rd_ready_i,
    output logic                     fifo_rd_valid_o,
    output logic                     fifo_flush_o,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [LEN_W-1:0]         drained_o,
    output logic                     abort_o
);

    localparam int               PTR_W   = $clog2(NUM_REQ);
    localparam logic [LEN_W-1:0] CNT_MAX = '1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_chk_num_req
        $error("fifo_flush_sched: NUM_REQ must be within 2..8");
    end
    if (WDOG_CYCLES < 1) begin : g_chk_wdog
        $error("fifo_flush_sched: WDOG_CYCLES must be at least 1");
    end

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_drained;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_flush;
    logic               r_done;
    logic               r_abort;

    logic [NUM_REQ-1:0] w_win;
    logic [PTR_W-1:0]   w_win_idx;
    logic [LEN_W-1:0]   w_len_arr [NUM_REQ];
    logic [LEN_W-1:0]   w_win_len;
    logic               w_finish;
    logic               w_rd;
    logic               w_last;
    logic               w_cnt_sat;
    logic               w_wdog_trip;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_req (req_i),
        .i_ptr (r_ptr),
        .o_gnt (w_win),
        .o_idx (w_win_idx)
    );

    // Unpack the flat length bus so the winner's slice can be picked by index.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_len
        assign w_len_arr[g] = len_i[g*LEN_W +: LEN_W];
    end
    assign w_win_len = w_len_arr[w_win_idx];

    // A counted drain ends once len words are read; a full flush ends when the FIFO shows empty.
    assign w_finish  = ((r_len != '0) && (r_drained == r_len)) ||
                       ((r_len == '0) && fifo_empty_i);

    // Read strobe is combinational so a word can pop every cycle both sides allow it.
    assign w_rd      = (r_state == ST_DRAIN) && !fifo_empty_i && rd_ready_i && !w_finish;

    // The read that brings the count up to len also ends the drain, so done_o follows it directly.
    assign w_last    = w_rd && (r_len != '0) && ((r_drained + LEN_W'(1)) == r_len);

    // Full flushes can pop more words than the counter holds; it sticks at all-ones.
    assign w_cnt_sat = (r_drained == CNT_MAX);

`ifdef FIFO_FLUSH_SCHED_WDOG_EN
    localparam int STALL_W = $clog2(WDOG_CYCLES + 1);

    logic [STALL_W-1:0] r_stall;

    // Trip on the cycle that would bring the consecutive-stall count to WDOG_CYCLES.
    assign w_wdog_trip = (r_state == ST_DRAIN) && !w_rd && !w_finish &&
                         (r_stall == STALL_W'(WDOG_CYCLES - 1));

    // Count consecutive DRAIN cycles without a read; any read or leaving DRAIN restarts it.
    always_ff @(posedge rclock or negedge reset) begin
        if (!reset) begin
            r_stall <= '0;
        end else if (r_state != ST_DRAIN || w_rd) begin
            r_stall <= '0;
        end else begin
            r_stall <= r_stall + STALL_W'(1);
        end
    end
`else
    // Without the watchdog a stalled drain simply waits for the FIFO or the consumer.
    assign w_wdog_trip = 1'b0;
`endif

    // Scheduler FSM: arbitrate in IDLE, pop words in DRAIN, pulse done in DONE.
    always_ff @(posedge rclock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_len     <= '0;
            r_drained <= '0;
            r_ptr     <= PTR_W'(NUM_REQ - 1);
            r_flush   <= 1'b0;
            r_done    <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req_i) begin
                        r_grant   <= w_win;
                        r_len     <= w_win_len;
                        r_drained <= '0;
                        r_ptr     <= w_win_idx;
                        r_flush   <= (w_win_len == '0);
                        r_state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_rd && !w_cnt_sat) begin
                        r_drained <= r_drained + LEN_W'(1);
                    end
                    if (w_finish || w_last || w_wdog_trip) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_abort <= w_wdog_trip;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_flush <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_valid_o = w_rd;
    assign fifo_flush_o    = r_flush;
    assign grant_o         = r_grant;
    assign busy_o          = (r_state != ST_IDLE);
    assign done_o          = r_done;
    assign drained_o       = r_drained;
    assign abort_o         = r_abort;

endmodule

// File: tb/tb_fifo_flush_sched.sv
// Bench for fifo_flush_sched: FIFO level model, drain scoreboard popped on done_o, directed cycle checks.
// Latency: n/a.
// Backpressure: rd_ready_i and a forced-empty override are driven by the stimulus.
`timescale 1ns/1ps
module tb_fifo_flush_sched;

    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 6;
    localparam int WDOG    = 8;

    logic                     rclock = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ*LEN_W-1:0] len_i;
    logic                     fifo_empty_i;
    logic                     rd_ready_i;
    logic                     fifo_rd_valid_o;
    logic                     fifo_flush_o;
    logic [NUM_REQ-1:0]       grant_o;
    logic                     busy_o;
    logic                     done_o;
    logic [LEN_W-1:0]         drained_o;
    logic                     abort_o;

    fifo_flush_sched #(
        .NUM_REQ     (NUM_REQ),
        .LEN_W       (LEN_W),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .rclock          (rclock),
        .reset           (reset),
        .req_i           (req_i),
        .len_i           (len_i),
        .fifo_empty_i    (fifo_empty_i),
        .rd_ready_i      (rd_ready_i),
        .fifo_rd_valid_o (fifo_rd_valid_o),
        .fifo_flush_o    (fifo_flush_o),
        .grant_o         (grant_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .drained_o       (drained_o),
        .abort_o         (abort_o)
    );

    always #5 rclock = ~rclock;

    // FIFO occupancy model: words pushed by stimulus minus words popped by the strobe.
    int   pushed      = 0;
    int   popped      = 0;
    logic force_empty = 1'b0;
    assign fifo_empty_i = (pushed == popped) || force_empty;

    always @(posedge rclock) begin
        if (fifo_rd_valid_o) popped <= popped + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard of expected grant outcomes, pushed when the request is driven.
    typedef struct {
        logic [NUM_REQ-1:0] grant;
        int                 drained;
        int                 strobes;
        logic               abort;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   strobes    = 0;
    int   bad_strobe = 0;
    int   done_cnt   = 0;

    // Monitor: count strobes per grant, flag illegal strobes, score each done_o pulse.
    always @(negedge rclock) begin
        if (!busy_o) strobes = 0;
        if (fifo_rd_valid_o) begin
            strobes++;
            if (fifo_empty_i || !rd_ready_i) bad_strobe++;
        end
        if (done_o) begin
            done_cnt++;
            check("sb_queue_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_grant",   grant_o,   e.grant);
                check("sb_drained", drained_o, e.drained);
                check("sb_strobes", strobes,   e.strobes);
                check("sb_abort",   abort_o,   e.abort);
            end
        end
    end

    task automatic tick();
        @(posedge rclock);
        #1;
    endtask

    task automatic fill(input int n);
        pushed = popped + n;
    endtask

    task automatic set_len(input int k, input int v);
        len_i[k*LEN_W +: LEN_W] = LEN_W'(v);
    endtask

    task automatic expect_done(input logic [NUM_REQ-1:0] g, input int d, input int s, input logic a);
        exp_t x;
        x.grant = g; x.drained = d; x.strobes = s; x.abort = a;
        exp_q.push_back(x);
    endtask

    // Advance until done_o is high or the budget expires; an expired budget fails the check.
    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_o !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, done_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got busy=%0d expected finish", busy_o);
        $fatal(1, "bench timeout");
    end

    initial begin
        int dc;
        reset = 1'b0; req_i = '0; len_i = '0; rd_ready_i = 1'b1;
        repeat (2) @(posedge rclock);
        @(negedge rclock);
        check("rst_grant",   grant_o,         0);
        check("rst_busy",    busy_o,          0);
        check("rst_done",    done_o,          0);
        check("rst_drained", drained_o,       0);
        check("rst_abort",   abort_o,         0);
        check("rst_flush",   fifo_flush_o,    0);
        check("rst_rdv",     fifo_rd_valid_o, 0);
        tick();
        reset = 1'b1;

        // Single counted drain with exact cycle timing; req and len change after grant.
        fill(5); set_len(0, 3); req_i = 4'b0001;
        expect_done(4'b0001, 3, 3, 1'b0);
        tick();
        check("t1_grant_c1", grant_o, 4'b0001);
        check("t1_rdv_c1",   fifo_rd_valid_o, 1);
        check("t1_busy_c1",  busy_o, 1);
        req_i = '0; set_len(0, 10);
        tick(); check("t1_rdv_c2", fifo_rd_valid_o, 1);
        tick(); check("t1_rdv_c3", fifo_rd_valid_o, 1);
        check("t1_drained_c3", drained_o, 2);
        tick();
        check("t1_done_c4",    done_o, 1);
        check("t1_rdv_c4",     fifo_rd_valid_o, 0);
        check("t1_drained_c4", drained_o, 3);
        check("t1_grant_c4",   grant_o, 4'b0001);
        tick();
        check("t1_grant_clr",  grant_o, 0);
        check("t1_done_once",  done_o, 0);
        check("t1_drained_hold", drained_o, 3);

        // Two held requests alternate round-robin with one idle cycle between grants.
        fill(6); set_len(1, 2); set_len(2, 2); req_i = 4'b0110;
        expect_done(4'b0010, 2, 2, 1'b0);
        expect_done(4'b0100, 2, 2, 1'b0);
        expect_done(4'b0010, 2, 2, 1'b0);
        tick();          check("t2_grant_a", grant_o, 4'b0010);
        repeat (3) tick(); check("t2_idle_gap", busy_o, 0);
        tick();          check("t2_grant_b", grant_o, 4'b0100);
        repeat (4) tick(); check("t2_grant_wrap", grant_o, 4'b0010);
        req_i = '0;
        wait_done("t2_done", 10);
        tick();

        // Full flush of 7 words, then a full flush of an already empty FIFO.
        fill(7); set_len(0, 0); req_i = 4'b0001;
        expect_done(4'b0001, 7, 7, 1'b0);
        tick();
        check("t3_flush",  fifo_flush_o, 1);
        check("t3_rdv_c1", fifo_rd_valid_o, 1);
        req_i = '0;
        wait_done("t3_done", 20);
        check("t3_flush_at_done", fifo_flush_o, 1);
        tick();
        check("t3_flush_clr", fifo_flush_o, 0);
        fill(0); req_i = 4'b0001;
        expect_done(4'b0001, 0, 0, 1'b0);
        tick();
        req_i = '0;
        check("t3e_rdv", fifo_rd_valid_o, 0);
        tick();
        check("t3e_done_c2", done_o, 1);
        tick();

        // Full flush of more words than the counter can hold: count saturates at 63.
        fill(70); req_i = 4'b0001;
        expect_done(4'b0001, 63, 70, 1'b0);
        tick();
        req_i = '0;
        wait_done("t3s_done", 100);
        tick();

        // Counted drain under toggling ready and a two-cycle empty window.
        fill(4); set_len(1, 4); req_i = 4'b0010;
        expect_done(4'b0010, 4, 4, 1'b0);
        tick();
        check("t4_grant", grant_o, 4'b0010);
        req_i = '0;
        for (int i = 0; i < 30; i++) begin
            rd_ready_i  = (i % 2 == 0);
            force_empty = (i == 2 || i == 3);
            if (done_o) break;
            tick();
        end
        rd_ready_i = 1'b1; force_empty = 1'b0;
        check("t4_done", done_o, 1);
        check("t4_no_bad_strobe", bad_strobe, 0);
        tick();

        // Stalled counted drain: 2 of 5 words available.
        fill(2); set_len(0, 5); req_i = 4'b0001;
`ifdef FIFO_FLUSH_SCHED_WDOG_EN
        expect_done(4'b0001, 2, 2, 1'b1);
        tick();
        req_i = '0;
        repeat (9) tick();
        check("t5_no_done_c10", done_o, 0);
        check("t5_busy_c10",    busy_o, 1);
        tick();
        check("t5_done_c11",  done_o, 1);
        check("t5_abort_c11", abort_o, 1);
        tick();
        check("t5_abort_once", abort_o, 0);
`else
        expect_done(4'b0001, 5, 5, 1'b0);
        tick();
        req_i = '0;
        dc = done_cnt;
        repeat (40) tick();
        check("t5_still_busy", busy_o, 1);
        check("t5_no_done",    done_cnt, dc);
        check("t5_drained",    drained_o, 2);
        check("t5_no_abort",   abort_o, 0);
        fill(3);
        wait_done("t5_done", 10);
        tick();
`endif

        // Reset mid-drain: outputs clear at once, no done pulse, req 0 wins first afterwards.
        fill(3); set_len(0, 3); req_i = 4'b0001;
        tick();
        check("t6_grant", grant_o, 4'b0001);
        req_i = '0;
        tick();
        check("t6_drained_mid", drained_o, 1);
        reset = 1'b0;
        #1;
        check("t6_rst_grant",   grant_o, 0);
        check("t6_rst_busy",    busy_o, 0);
        check("t6_rst_drained", drained_o, 0);
        check("t6_rst_rdv",     fifo_rd_valid_o, 0);
        check("t6_rst_flush",   fifo_flush_o, 0);
        dc = done_cnt;
        tick(); tick();
        check("t6_no_done", done_cnt, dc);
        reset = 1'b1;
        len_i = {NUM_REQ{6'd1}}; req_i = 4'b1111;
        expect_done(4'b0001, 1, 1, 1'b0);
        tick();
        check("t6_first_after_rst", grant_o, 4'b0001);
        req_i = '0;
        wait_done("t6_done", 10);
        tick();

        check("sb_all_scored", exp_q.size(), 0);
        check("no_bad_strobe", bad_strobe, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
